// File: rtl/pingpong_buffer_pkg.sv
// pingpong_buffer_pkg: default geometry and errFlags bit positions for the ping-pong buffer.
package pingpong_buffer_pkg;
    localparam int DATA_W_DEF    = 18;
    localparam int ADDR_W_DEF    = 10;
    localparam int ERR_OVERFLOW  = 0;
    localparam int ERR_UNDERFLOW = 1;
endpackage

// File: rtl/pingpong_buffer_if.sv
// pingpong_buffer_if: producer/consumer bus of the ping-pong buffer; master drives, slave is the buffer.
interface pingpong_buffer_if
    import pingpong_buffer_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);
    logic              writeValid;
    logic [DATA_W-1:0] writeData;
    logic              writeLast;
    logic              writeReady;
    logic              readAvail;
    logic [ADDR_W:0]   readLen;
    logic              readEn;
    logic [ADDR_W-1:0] readAddr;
    logic [DATA_W-1:0] readData;
    logic              readDone;
    logic [1:0]        errFlags;

    modport master (
        output writeValid, writeData, writeLast, readEn, readAddr, readDone,
        input  writeReady, readAvail, readLen, readData, errFlags
    );
    modport slave (
        input  writeValid, writeData, writeLast, readEn, readAddr, readDone,
        output writeReady, readAvail, readLen, readData, errFlags
    );
endinterface

// File: rtl/pingpong_buffer_sdp_ram_bank.sv
// sdp_ram_bank: simple dual-port RAM, one write port and one registered read port that holds when idle.
module sdp_ram_bank #(
    parameter int DATA_W = 18,
    parameter int ADDR_W = 10
) (
    input  logic              CLK,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge CLK) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/pingpong_buffer.sv
// pingpong_buffer: two-bank ping-pong buffer with commit/release hand-over.
// Define PPBUF_ERR_EN to enable the sticky overflow/underflow errFlags.
module pingpong_buffer
    import pingpong_buffer_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input logic              CLK,
    input logic              RST,
    pingpong_buffer_if.slave bus
);
    logic              wr_bank, rd_bank;
    logic [ADDR_W-1:0] wr_ptr;
    logic [1:0]        full;
    logic [ADDR_W:0]   len [2];
    logic              rd_sel, rd_vld;
    logic [DATA_W-1:0] q [2];
    logic              wr_acc, commit, rd_acc, rel;

    assign wr_acc = bus.writeValid && !full[wr_bank];
    assign commit = wr_acc && (bus.writeLast || wr_ptr == '1);
    assign rd_acc = bus.readEn && full[rd_bank];
    assign rel    = bus.readDone && full[rd_bank];

    assign bus.writeReady = !full[wr_bank];
    assign bus.readAvail  = full[rd_bank];
    assign bus.readLen    = len[rd_bank];
    // The RAM read port holds its word, so remembering which bank was last read keeps readData stable.
    assign bus.readData   = rd_vld ? q[rd_sel] : '0;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        sdp_ram_bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
            .CLK   (CLK),
            .we    (wr_acc && wr_bank == 1'(b)),
            .waddr (wr_ptr),
            .wdata (bus.writeData),
            .re    (rd_acc && rd_bank == 1'(b)),
            .raddr (bus.readAddr),
            .rdata (q[b])
        );
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_ptr  <= '0;
            full    <= '0;
            len     <= '{default: '0};
            rd_sel  <= 1'b0;
            rd_vld  <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= commit ? '0 : wr_ptr + 1'b1;
            if (commit) begin
                full[wr_bank] <= 1'b1;
                len[wr_bank]  <= {1'b0, wr_ptr} + 1'b1;
                wr_bank       <= ~wr_bank;
            end
            // Commit and release always target different banks, so both may land together.
            if (rel) begin
                full[rd_bank] <= 1'b0;
                rd_bank       <= ~rd_bank;
            end
            if (rd_acc) begin
                rd_sel <= rd_bank;
                rd_vld <= 1'b1;
            end
        end
    end

`ifdef PPBUF_ERR_EN
    logic [1:0] err;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) err <= '0;
        else begin
            if (bus.writeValid && full[wr_bank]) err[ERR_OVERFLOW] <= 1'b1;
            if ((bus.readEn || bus.readDone) && !full[rd_bank]) err[ERR_UNDERFLOW] <= 1'b1;
        end
    end

    assign bus.errFlags = err;
`else
    assign bus.errFlags = '0;
`endif
endmodule

// File: tb/tb_pingpong_buffer.sv
// tb_pingpong_buffer: scoreboard bench against a frame-FIFO reference model of the ping-pong buffer.
module tb_pingpong_buffer;
    import pingpong_buffer_pkg::*;
    localparam int DW = DATA_W_DEF;
    localparam int AW = ADDR_W_DEF;
    localparam int DEPTH = 1 << AW;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    pingpong_buffer_if #(.DATA_W(DW), .ADDR_W(AW)) bus();
    pingpong_buffer #(.DATA_W(DW), .ADDR_W(AW)) dut (.CLK(CLK), .RST(RST), .bus(bus.slave));

    typedef struct {bit chk; logic [DW-1:0] d;} exp_t;
    exp_t sb[$];
    int total = 0;
    int bad = 0;

    // Reference: committed frames form a FIFO of at most two; cur is the frame being written.
    logic [DW-1:0] fr [2][DEPTH];
    int fr_len[2];
    int head = 0;
    int cnt = 0;
    bit fresh = 1;
    logic [DW-1:0] cur[$];
    logic [1:0] err_m = 2'b00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit v, input logic [DW-1:0] d, input bit l,
                         input bit en, input logic [AW-1:0] a, input bit dn);
        exp_t e;
        bit acc, rel, com;
        int tail;
        bus.writeValid = v;
        bus.writeData  = d;
        bus.writeLast  = l;
        bus.readEn     = en;
        bus.readAddr   = a;
        bus.readDone   = dn;
        @(negedge CLK);
        chk("writeReady", 32'(bus.writeReady), 32'(cnt < 2));
        chk("readAvail", 32'(bus.readAvail), 32'(cnt > 0));
        if (cnt > 0 || fresh) chk("readLen", 32'(bus.readLen), cnt > 0 ? 32'(fr_len[head]) : 32'd0);
`ifdef PPBUF_ERR_EN
        chk("errFlags", 32'(bus.errFlags), 32'(err_m));
        if (v && cnt == 2) err_m[ERR_OVERFLOW] = 1'b1;
        if ((en || dn) && cnt == 0) err_m[ERR_UNDERFLOW] = 1'b1;
`else
        chk("errFlags", 32'(bus.errFlags), 32'd0);
`endif
        if (en && cnt > 0) begin
            e.chk = 32'(a) < fr_len[head];
            e.d   = fr[head][a];
            sb.push_back(e);
        end
        acc  = v && cnt < 2;
        rel  = dn && cnt > 0;
        com  = 0;
        tail = (head + cnt) % 2;
        if (acc) begin
            cur.push_back(d);
            if (l || cur.size() == DEPTH) begin
                foreach (cur[i]) fr[tail][i] = cur[i];
                fr_len[tail] = cur.size();
                cur.delete();
                com = 1;
                fresh = 0;
            end
        end
        if (rel) begin
            head = 1 - head;
            cnt--;
        end
        if (com) cnt++;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        drive(0, '0, 0, 0, '0, 0);
    endtask

    task automatic do_reset();
        bus.writeValid = 0; bus.writeData = '0; bus.writeLast = 0;
        bus.readEn = 0; bus.readAddr = '0; bus.readDone = 0;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        @(negedge CLK);
        chk("rst_writeReady", 32'(bus.writeReady), 32'd1);
        chk("rst_readAvail", 32'(bus.readAvail), 32'd0);
        chk("rst_readLen", 32'(bus.readLen), 32'd0);
        chk("rst_readData", 32'(bus.readData), 32'd0);
        chk("rst_errFlags", 32'(bus.errFlags), 32'd0);
        sb.delete();
        cur.delete();
        cnt = 0;
        head = 0;
        fresh = 1;
        err_m = 2'b00;
        @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    // Monitor: compares readData one cycle after each accepted read, otherwise checks that it holds.
    bit pend = 0;
    bit known = 1;
    logic [DW-1:0] last_d = '0;
    exp_t me;
    always @(negedge CLK) begin
        if (RST) begin
            pend = 0;
            known = 1;
            last_d = '0;
        end else begin
            if (pend) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_underrun: actual=read_seen required=no_read");
                end else begin
                    me = sb.pop_front();
                    if (me.chk) chk("readData", 32'(bus.readData), 32'(me.d));
                    last_d = me.d;
                    known = me.chk;
                end
            end else if (known) chk("readHold", 32'(bus.readData), 32'(last_d));
            pend = bus.readEn && bus.readAvail;
        end
    end

    initial begin
        bit rv, rl, ren, rdn;
        logic [AW-1:0] ra;
        do_reset();
        // Short frame, read back, release.
        for (int i = 1; i <= 4; i++) drive(1, DW'(i), i == 4, 0, '0, 0);
        drive(0, '0, 0, 1, AW'(2), 0);
        drive(0, '0, 0, 0, '0, 1);
        // Full-depth frame auto-commits into bank 1.
        for (int i = 0; i < DEPTH; i++) drive(1, DW'(i * 7 + 3), 0, 0, '0, 0);
        idle();
        // Fill the other bank, then blocked writes, then release.
        for (int i = 0; i < 5; i++) drive(1, DW'(32'h2a000 + i), i == 4, 0, '0, 0);
        drive(0, '0, 0, 1, AW'(DEPTH - 1), 0);
        for (int i = 0; i < 3; i++) drive(1, DW'(32'h3ffff), 0, 0, '0, 0);
        drive(0, '0, 0, 0, '0, 1);
        idle();
        // Commit and release in the same cycle, with a read from the old bank.
        drive(1, DW'(32'h111), 0, 0, '0, 0);
        drive(1, DW'(32'h222), 0, 0, '0, 0);
        drive(1, DW'(32'h333), 1, 1, AW'(4), 1);
        drive(0, '0, 0, 1, AW'(0), 0);
        drive(0, '0, 0, 0, '0, 1);
        // Underflow: read and release with nothing committed.
        drive(0, '0, 0, 1, AW'(7), 1);
        idle();
        // Reset mid-frame, then a fresh two-word frame.
        for (int i = 0; i < 3; i++) drive(1, DW'(32'h15 + i), 0, 0, '0, 0);
        do_reset();
        drive(1, DW'(32'h0abc), 0, 0, '0, 0);
        drive(1, DW'(32'h0def), 1, 0, '0, 0);
        drive(0, '0, 0, 1, AW'(0), 0);
        drive(0, '0, 0, 1, AW'(1), 1);
        idle();
        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            rv  = $urandom_range(0, 3) != 0;
            rl  = $urandom_range(0, 63) == 0;
            ren = $urandom_range(0, 1) == 1;
            rdn = cnt > 0 ? $urandom_range(0, 39) == 0 : $urandom_range(0, 199) == 0;
            if (cnt > 0 && $urandom_range(0, 7) != 0) ra = AW'($urandom_range(0, fr_len[head] - 1));
            else ra = AW'($urandom());
            drive(rv, DW'($urandom()), rl, ren, ra, rdn);
        end
        idle();
        idle();
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pingpong_buffer.md
# pingpong_buffer

Parametrised two-bank ping-pong buffer with automatic bank hand-over: a producer streams words into one bank while a consumer randomly reads a committed frame from the other. Banks swap ownership through a commit/release handshake rather than an external switch line. Sits between the path-generation stage and the risk-accumulation stage of the calculation pipeline, decoupling frame production from frame consumption.

## Interface

- DATA_W, 18, word width in bits
- ADDR_W, 10, address width; bank depth DEPTH = 2**ADDR_W
- CLK  in  1  rising-edge clock
- RST  in  1  asynchronous, active-high reset
- writeValid  in  1  producer presents a word
- writeData  in  DATA_W  word to store
- writeLast  in  1  word is the last of the frame (qualified by writeValid)
- writeReady  out  1  write bank is free; word accepted when writeValid && writeReady
- readAvail  out  1  a committed frame is readable
- readLen  out  ADDR_W+1  word count of the readable frame (1..DEPTH)
- readEn  in  1  read strobe
- readAddr  in  ADDR_W  word address within the readable frame
- readData  out  DATA_W  registered read word
- readDone  in  1  consumer releases the readable bank
- errFlags  out  2  sticky errors (only with PPBUF_ERR_EN; see Configuration)

## Operation

- State: wrBank, rdBank (1 bit each), wrPtr (ADDR_W), full[1:0], len[1:0] (ADDR_W+1 each).
- writeReady = !full[wrBank]; readAvail = full[rdBank]; readLen = len[rdBank].
- Accepted write: bank[wrBank][wrPtr] <= writeData; wrPtr++.
- Commit: on accepted write with writeLast, or with wrPtr == DEPTH-1: full[wrBank] <= 1, len[wrBank] <= wrPtr+1, wrBank toggles, wrPtr <= 0. Full-bank commit without writeLast is a normal frame of DEPTH words.
- Read: readEn && readAvail -> readData <= bank[rdBank][readAddr]; otherwise readData holds. Addresses >= readLen return whatever the bank holds (undefined content, no error).
- Release: readDone && readAvail -> full[rdBank] <= 0, rdBank toggles. readDone with !readAvail ignored.
- Read and release in the same cycle: the read completes from the old rdBank.
- Commit and release in the same cycle: both take effect (always different banks, since commit requires !full and release requires full).
- Write while !writeReady: word dropped, wrPtr unchanged.
- Reset: wrBank=rdBank=0, wrPtr=0, full=0, len=0, readData=0, errFlags=0; writeReady=1, readAvail=0, readLen=0. Any partially written frame is discarded. RAM contents not reset.

## Timing

- Write-to-readable latency: commit edge sets full; readAvail high in the cycle after the committing write.
- Read latency: 1 cycle (readData valid after the edge that samples readEn).
- Release: writeReady for a blocked producer rises the cycle after readDone.
- Sustained throughput: 1 word/cycle write and 1 word/cycle read concurrently; no bubble at bank swap if the other bank is free.

## Configuration

- PPBUF_ERR_EN defined: errFlags[0] sets on writeValid && !writeReady (overflow); errFlags[1] sets on (readEn || readDone) && !readAvail (underflow). Sticky until RST.
- Undefined: errFlags tied to 0, no error logic synthesised.

## Structure

- Package pingpong_buffer_pkg: default DATA_W/ADDR_W constants, errFlags bit indices (ERR_OVERFLOW=0, ERR_UNDERFLOW=1).
- Sub-module sdp_ram_bank (simple dual-port, one write port, one registered read port), instantiated twice; top-level holds pointers, flags, lengths and the readData mux.

## Test plan

- Reset then write 4 words 0x1..0x4 with writeLast on 0x4 -> readAvail=1 next cycle, readLen=4; read addr 2 -> readData=0x3 one cycle later.
- Write 1024 words without writeLast (ADDR_W=10) -> auto-commit, readLen=1024, wrPtr wraps to 0, writeReady stays 1 (bank 1 free).
- Fill both banks without readDone -> writeReady=0; further writes dropped (errFlags[0]=1 with PPBUF_ERR_EN); readDone -> writeReady=1 next cycle.
- Same-cycle commit of bank 1 and readDone on bank 0 -> readAvail stays 1, readLen switches to bank 1 length, writeReady=1.
- readEn/readDone with readAvail=0 -> readData unchanged, no state change, errFlags[1]=1 with macro, 0 without.
- Assert RST mid-frame after 3 writes -> all outputs to reset values; new frame of 2 words then reads back correctly from bank 0.
